// File: rtl/tdc_trace_reader.sv
// tdc_trace_reader: decodes TDC carry-chain snapshots into ones-counts,
// buffers one capture window per arm, then streams it as a framed byte
// stream (0xA5, count hi, count lo, samples) over a valid/ready port.
// Optional build macro TDC_CHECKSUM_EN appends an XOR checksum byte.
module tdc_trace_reader #(
    parameter  int TAP_W = 64,
    parameter  int DEPTH = 1024,
    localparam int CNT_W = $clog2(TAP_W + 1)
) (
    input  logic             clk_capture,
    input  logic             rst_n,
    input  logic [TAP_W-1:0] tdc_data,
    input  logic             data_valid,
    input  logic             arm,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             overflow
);
    localparam int GRPS   = TAP_W / 8;
    localparam int STAGES = 2;
    localparam int AW     = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, FLUSH, DUMP} state_t;
    state_t state;

    logic [STAGES:1]          vld_pipe;
    logic [GRPS-1:0][3:0]     grp_pc, s1_pc;
    logic [CNT_W-1:0]         pc_sum, s2_sum;
    logic [15:0]              count;
    logic [CNT_W-1:0]         mem [DEPTH];
    logic [CNT_W-1:0]         rd_data;
    logic [AW-1:0]            rd_addr;
    logic [16:0]              ra_full, nidx, total;
    logic                     flush_cnt;
    logic                     s_in, wr, fill, load;
    logic [7:0]               nbyte;
`ifdef TDC_CHECKSUM_EN
    logic [7:0]               csum;
`endif

    // A sample enters S1 only while a trace is armed or capturing.
    assign s_in = data_valid && (state == ARMED || state == CAPTURE);
    // S2 writes at addr=count; the write that fills the buffer truncates the trace.
    assign wr   = vld_pipe[2] && (count != 16'(DEPTH));
    assign fill = wr && (count == 16'(DEPTH - 1));
    // Output register can take a new byte when empty or being drained.
    assign load = !tx_valid || tx_ready;
    assign busy = (state != IDLE);

`ifdef TDC_CHECKSUM_EN
    assign total = 17'(count) + 17'd4;
`else
    assign total = 17'(count) + 17'd3;
`endif

    // Group popcounts for S1 and their sum for S2 (sum fits CNT_W, max TAP_W).
    always_comb begin
        for (int g = 0; g < GRPS; g++) begin
            grp_pc[g] = '0;
            for (int b = 0; b < 8; b++) grp_pc[g] = grp_pc[g] + 4'(tdc_data[g*8+b]);
        end
        pc_sum = '0;
        for (int g = 0; g < GRPS; g++) pc_sum = pc_sum + CNT_W'(s1_pc[g]);
    end

    // Decode pipeline; a filling write squashes everything still in flight.
    always_ff @(posedge clk_capture or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_pc    <= '0;
            s2_sum   <= '0;
        end else begin
            vld_pipe <= fill ? '0 : {vld_pipe[1], s_in};
            s1_pc    <= grp_pc;
            s2_sum   <= pc_sum;
        end
    end

    // Read address leads the frame index by one byte so RAM data is ready on load.
    always_comb begin
        ra_full = load ? nidx - 17'd2 : nidx - 17'd3;
        rd_addr = ra_full[AW-1:0];
    end

    // Sample buffer: write from S2, 1-cycle synchronous read.
    always_ff @(posedge clk_capture) begin
        if (wr) mem[count[AW-1:0]] <= s2_sum;
        rd_data <= mem[rd_addr];
    end

    // Byte selected for frame position nidx.
    always_comb begin
        nbyte = 8'h00;
        if (nidx == 17'd0)                       nbyte = 8'hA5;
        else if (nidx == 17'd1)                  nbyte = count[15:8];
        else if (nidx == 17'd2)                  nbyte = count[7:0];
        else if (nidx < 17'(count) + 17'd3)      nbyte = 8'(rd_data);
`ifdef TDC_CHECKSUM_EN
        else                                     nbyte = csum;
`endif
    end

    // Trace FSM, sample counter and registered stream output.
    always_ff @(posedge clk_capture or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            overflow  <= 1'b0;
            count     <= '0;
            nidx      <= '0;
            flush_cnt <= 1'b0;
`ifdef TDC_CHECKSUM_EN
            csum      <= 8'h00;
`endif
        end else begin
            if (wr)   count    <= count + 16'd1;
            if (fill) overflow <= 1'b1;
            case (state)
                IDLE: if (arm) begin
                    state    <= ARMED;
                    overflow <= 1'b0;
                    count    <= '0;
                end
                ARMED: if (data_valid) state <= CAPTURE;
                CAPTURE: if (!data_valid || fill) begin
                    state     <= FLUSH;
                    flush_cnt <= 1'b0;
                end
                FLUSH: begin
                    flush_cnt <= 1'b1;
                    if (flush_cnt) begin
                        state <= DUMP;
                        nidx  <= '0;
`ifdef TDC_CHECKSUM_EN
                        csum  <= 8'h00;
`endif
                    end
                end
                DUMP: if (load) begin
                    if (nidx != total) begin
                        tx_valid <= 1'b1;
                        tx_data  <= nbyte;
                        nidx     <= nidx + 17'd1;
`ifdef TDC_CHECKSUM_EN
                        csum     <= csum ^ nbyte;
`endif
                    end else begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tdc_trace_reader.sv
// Randomized bench for tdc_trace_reader against a frame-level reference model.
module tb_tdc_trace_reader;
    localparam int TAP_W = 64;
    localparam int DEPTH = 16;

    logic             clk_capture = 1'b0;
    logic             rst_n = 1'b0;
    logic [TAP_W-1:0] tdc_data = '0;
    logic             data_valid = 1'b0;
    logic             arm = 1'b0;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready = 1'b0;
    logic             busy;
    logic             overflow;

    tdc_trace_reader #(.TAP_W(TAP_W), .DEPTH(DEPTH)) u_dut (
        .clk_capture(clk_capture), .rst_n(rst_n), .tdc_data(tdc_data),
        .data_valid(data_valid), .arm(arm), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .overflow(overflow)
    );

    always #5 clk_capture = ~clk_capture;

    int         nchk = 0, nerr = 0;
    int         rdy_pct = 100;
    logic       stalled = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] got[$];
    logic [63:0] samp[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // One cycle: check hold-while-stalled, drive inputs, log the transfer at the next edge.
    task automatic step(input logic dv, input logic [63:0] d, input logic a);
        @(negedge clk_capture);
        if (stalled) begin
            chk("hold_valid", 32'(tx_valid), 32'd1);
            chk("hold_data", 32'(tx_data), 32'(held));
        end
        data_valid = dv;
        tdc_data   = d;
        arm        = a;
        tx_ready   = ($urandom_range(99) < rdy_pct);
        if (tx_valid && tx_ready) got.push_back(tx_data);
        stalled = tx_valid && !tx_ready;
        held    = tx_data;
    endtask

    // Arm, feed samp[], wait for the frame, compare with the model.
    task automatic run_trace(input logic arm_dv, input logic arm_cap, input logic arm_dump);
        logic [7:0] exp[$];
        logic [7:0] cs;
        int         n, cnt;
        logic       armed_dump;
        n = samp.size();
        got.delete();
        step(arm_dv, rand64(), 1'b1);
        for (int i = 0; i < n; i++) begin
            step(1'b1, samp[i], arm_cap && (i == 1));
            if (i == 0) chk("ovf_clear", 32'(overflow), 32'd0);
        end
        step(1'b0, '0, 1'b0);
        armed_dump = 1'b0;
        for (int k = 0; k < 4000 && busy; k++) begin
            step(1'b0, '0, arm_dump && tx_valid && !armed_dump);
            if (tx_valid) armed_dump = 1'b1;
        end
        // model: header, min(n,DEPTH) ones-counts, optional XOR checksum
        cnt = (n < DEPTH) ? n : DEPTH;
        exp.push_back(8'hA5);
        exp.push_back(8'(cnt >> 8));
        exp.push_back(8'(cnt & 255));
        for (int i = 0; i < cnt; i++) exp.push_back(8'($countones(samp[i])));
`ifdef TDC_CHECKSUM_EN
        cs = 8'h00;
        foreach (exp[i]) cs = cs ^ exp[i];
        exp.push_back(cs);
`else
        cs = 8'h00;
`endif
        chk("busy_done", 32'(busy), 32'd0);
        chk("frame_len", 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("byte%0d", i), 32'(got[i]), 32'(exp[i]));
        chk("overflow", 32'(overflow), 32'(n >= DEPTH));
    endtask

    initial begin
        #12;
        chk("rst_txv", 32'(tx_valid), 32'd0);
        chk("rst_txd", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk_capture); rst_n = 1'b1;

        // 1: three fixed samples, full-rate sink
        samp = '{64'h0, 64'hFF, {64{1'b1}}};
        run_trace(1'b0, 1'b0, 1'b0);

        // 2: samples before arm are ignored; then one 0xF sample
        for (int i = 0; i < 3; i++) step(1'b1, rand64(), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
        chk("noarm_busy", 32'(busy), 32'd0);
        chk("noarm_txv", 32'(tx_valid), 32'd0);
        samp = '{64'hF};
        run_trace(1'b1, 1'b0, 1'b0);

        // 3: overrun, then a new arm clears overflow
        samp.delete();
        for (int i = 0; i < DEPTH + 4; i++) samp.push_back(rand64());
        run_trace(1'b0, 1'b0, 1'b0);
        samp = '{rand64(), rand64()};
        run_trace(1'b0, 1'b0, 1'b0);

        // 4: 16 samples with 50% backpressure
        rdy_pct = 50;
        samp.delete();
        for (int i = 0; i < 16; i++) samp.push_back(rand64());
        run_trace(1'b0, 1'b0, 1'b0);

        // 6: arm during capture and during dump is ignored
        samp.delete();
        for (int i = 0; i < 6; i++) samp.push_back(rand64());
        run_trace(1'b0, 1'b1, 1'b1);

        // random traces
        for (int t = 0; t < 6; t++) begin
            rdy_pct = $urandom_range(30, 100);
            samp.delete();
            for (int i = 0, n = $urandom_range(1, 20); i < n; i++) samp.push_back(rand64());
            run_trace(1'($urandom_range(1)), 1'b0, 1'b0);
        end

        // 5: reset mid-dump, then a fresh frame
        rdy_pct = 100;
        samp.delete();
        for (int i = 0; i < 5; i++) samp.push_back(rand64());
        got.delete();
        step(1'b0, '0, 1'b1);
        foreach (samp[i]) step(1'b1, samp[i], 1'b0);
        step(1'b0, '0, 1'b0);
        for (int k = 0; k < 400 && got.size() < 3; k++) step(1'b0, '0, 1'b0);
        chk("dump_reached", 32'(got.size() >= 3), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_txv", 32'(tx_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge clk_capture);
        rst_n = 1'b1;
        stalled = 1'b0;
        samp = '{rand64(), rand64()};
        run_trace(1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
